div_unit: RTL and testbench



---
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Sequential signed (one's-complement sign-magnitude) 32/16 restoring divider, BPC quotient bits per cycle.
// Optional macro DIV_UNIT_EARLY_TERM_EN skips the iteration when |dividend| < |divisor|.
module div_unit #(
  parameter int BPC = 1
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  localparam int N  = 32 / BPC;
  localparam int CW = 6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_dmag;
  logic [15:0]     r_vmag;
  logic [16:0]     r_rem;
  logic            r_qsign;
  logic            r_rsign;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_quot;
  logic [15:0]     r_remOut;
  logic            r_dbz;

  logic [31:0]     w_dmagIn;
  logic [15:0]     w_vmagIn;
  logic            w_qsignIn;
  logic            w_rsignIn;
  logic            w_zeroDiv;
  logic            w_early;
  logic            w_accept;
  logic            w_lastCalc;
  logic [16:0]     w_stepRem;
  logic [31:0]     w_stepQuot;

  assign w_dmagIn   = dividend[31] ? ~dividend : dividend;
  assign w_vmagIn   = divisor[15] ? ~divisor : divisor;
  assign w_qsignIn  = dividend[31] ^ divisor[15];
  assign w_rsignIn  = dividend[31];
  assign w_zeroDiv  = (w_vmagIn == 16'h0000);
  assign w_accept   = in_valid && in_ready;
  assign w_lastCalc = (r_cnt == CW'(N - 1));

`ifdef DIV_UNIT_EARLY_TERM_EN
  assign w_early = !w_zeroDiv && (w_dmagIn < {16'b0, w_vmagIn});
`else
  assign w_early = 1'b0;
`endif

  // r_dmag doubles as the quotient shift register: dividend bits leave at the top,
  // quotient bits enter at the bottom, so after N cycles it holds qmag.
  always_comb begin
    w_stepRem  = r_rem;
    w_stepQuot = r_dmag;
    for (int i = 0; i < BPC; i++) begin
      w_stepRem  = {w_stepRem[15:0], w_stepQuot[31]};
      w_stepQuot = {w_stepQuot[30:0], 1'b0};
      if (w_stepRem >= {1'b0, r_vmag}) begin
        w_stepRem     = w_stepRem - {1'b0, r_vmag};
        w_stepQuot[0] = 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = (w_zeroDiv || w_early) ? DONE : CALC;
      CALC: if (w_lastCalc) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_dmag   <= '0;
      r_vmag   <= '0;
      r_rem    <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_remOut <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dmag  <= w_dmagIn;
            r_vmag  <= w_vmagIn;
            r_qsign <= w_qsignIn;
            r_rsign <= w_rsignIn;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_dbz   <= w_zeroDiv;
            // Short paths finish here; both leave the dividend's low half as the remainder.
            if (w_zeroDiv || w_early) begin
              r_quot   <= (w_zeroDiv ^ w_qsignIn) ? 32'hFFFF_FFFF : 32'h0000_0000;
              r_remOut <= w_rsignIn ? ~w_dmagIn[15:0] : w_dmagIn[15:0];
            end
          end
        end
        CALC: begin
          r_rem  <= w_stepRem;
          r_dmag <= w_stepQuot;
          r_cnt  <= r_cnt + CW'(1);
          if (w_lastCalc) begin
            r_quot   <= r_qsign ? ~w_stepQuot : w_stepQuot;
            r_remOut <= r_rsign ? ~w_stepRem[15:0] : w_stepRem[15:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE) && !nvdla_core_rst;
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remOut;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (BPC=1); latency expectations follow DIV_UNIT_EARLY_TERM_EN.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        outValid;
  logic        outReady;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        divByZero;

  int errors = 0;
  int checks = 0;

`ifdef DIV_UNIT_EARLY_TERM_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 33;
`endif
  localparam int FULL_LAT = 33;
  localparam int ZERO_LAT = 1;

  div_unit #(.BPC(1)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .in_valid(inValid),
    .in_ready(inReady),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(outValid),
    .out_ready(outReady),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE, wait for out_valid, check result and latency.
  // With doHs set, out_ready is assumed high and the return to IDLE is checked too.
  task automatic applyStimulus(input string tag, input logic [31:0] dd, input logic [15:0] dv,
                               input logic [31:0] expQ, input logic [15:0] expR,
                               input logic expDbz, input int expLat, input bit doHs);
    int lat;
    bit busyOk;
    checkOutput({tag, ".idle_ready"}, 32'(inReady), 32'd1);
    inValid  = 1'b1;
    dividend = dd;
    divisor  = dv;
    tick();
    inValid  = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h0000;
    lat      = 1;
    busyOk   = 1'b1;
    while (outValid !== 1'b1 && lat < 100) begin
      if (inReady !== 1'b0) busyOk = 1'b0;
      tick();
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".busy_not_ready"}, 32'(busyOk), 32'd1);
    checkOutput({tag, ".done_not_ready"}, 32'(inReady), 32'd0);
    checkOutput({tag, ".quotient"}, quotient, expQ);
    checkOutput({tag, ".remainder"}, 32'(remainder), 32'(expR));
    checkOutput({tag, ".div_by_zero"}, 32'(divByZero), 32'(expDbz));
    if (doHs) begin
      tick();
      checkOutput({tag, ".valid_drop"}, 32'(outValid), 32'd0);
      checkOutput({tag, ".ready_back"}, 32'(inReady), 32'd1);
    end
  endtask

  initial begin
    int seen;
    rst      = 1'b1;
    inValid  = 1'b0;
    dividend = '0;
    divisor  = '0;
    outReady = 1'b1;
    tick();
    tick();
    checkOutput("rst.in_ready", 32'(inReady), 32'd0);
    checkOutput("rst.out_valid", 32'(outValid), 32'd0);
    checkOutput("rst.quotient", quotient, 32'd0);
    checkOutput("rst.remainder", 32'(remainder), 32'd0);
    checkOutput("rst.div_by_zero", 32'(divByZero), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst.in_ready", 32'(inReady), 32'd1);

    applyStimulus("pos_pos", 32'h0000_0064, 16'h0007, 32'h0000_000E, 16'h0002, 1'b0, FULL_LAT, 1'b1);
    applyStimulus("neg_pos", 32'hFFFF_FF9B, 16'h0007, 32'hFFFF_FFF1, 16'hFFFD, 1'b0, FULL_LAT, 1'b1);
    applyStimulus("pos_neg", 32'h0000_0064, 16'hFFF8, 32'hFFFF_FFF1, 16'h0002, 1'b0, FULL_LAT, 1'b1);
    applyStimulus("zero_pos", 32'h0000_1234, 16'h0000, 32'hFFFF_FFFF, 16'h1234, 1'b1, ZERO_LAT, 1'b1);
    applyStimulus("zero_neg", 32'h0000_1234, 16'hFFFF, 32'h0000_0000, 16'h1234, 1'b1, ZERO_LAT, 1'b1);
    applyStimulus("max_by1", 32'h7FFF_FFFF, 16'h0001, 32'h7FFF_FFFF, 16'h0000, 1'b0, FULL_LAT, 1'b1);
    applyStimulus("max_by7fff", 32'h7FFF_FFFF, 16'h7FFF, 32'h0001_0002, 16'h0001, 1'b0, FULL_LAT, 1'b1);
    applyStimulus("minneg_by2", 32'h8000_0000, 16'h0002, 32'hC000_0000, 16'hFFFE, 1'b0, FULL_LAT, 1'b1);
    applyStimulus("negzero_dd", 32'hFFFF_FFFF, 16'h0005, 32'hFFFF_FFFF, 16'hFFFF, 1'b0, SMALL_LAT, 1'b1);
    applyStimulus("small", 32'h0000_0003, 16'h0009, 32'h0000_0000, 16'h0003, 1'b0, SMALL_LAT, 1'b1);

    // Back-pressure: results and out_valid must hold while out_ready is low.
    outReady = 1'b0;
    applyStimulus("hold", 32'h0001_0000, 16'h0100, 32'h0000_0100, 16'h0000, 1'b0, FULL_LAT, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold.valid", 32'(outValid), 32'd1);
      checkOutput("hold.quotient", quotient, 32'h0000_0100);
      checkOutput("hold.remainder", 32'(remainder), 32'd0);
    end
    outReady = 1'b1;
    tick();
    checkOutput("hold.release_valid", 32'(outValid), 32'd0);
    checkOutput("hold.release_ready", 32'(inReady), 32'd1);

    // Reset during the 5th CALC cycle discards the operation.
    inValid  = 1'b1;
    dividend = 32'h0000_0064;
    divisor  = 16'h0007;
    tick();
    inValid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst.in_ready_low", 32'(inReady), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst.in_ready_after", 32'(inReady), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (outValid !== 1'b0) seen++;
      tick();
    end
    checkOutput("midrst.no_valid", 32'(seen), 32'd0);
    applyStimulus("after_rst", 32'h0000_0064, 16'h0007, 32'h0000_000E, 16'h0002, 1'b0, FULL_LAT, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
